ifetch_unit: RTL and testbench

- Fetch stage directly downstream of the program counter.
- Takes the current PC value, fetches the instruction word from a handshaked instruction memory, and holds it in an instruction register for decode under a valid/ready handshake.
- Produces a one-cycle pc_advance pulse that permits the PC to update.
- Supports redirect flush (jump or taken branch) and a bounded-wait timeout that substitutes a NOP.

---
 rtl/ifetch_pkg.sv | 14 +
 rtl/ifetch_unit_fetch_timer.sv | 30 +++
 rtl/ifetch_unit.sv | 120 ++++++++++++
 tb/tb_ifetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    localparam int          TIMEOUT_DEF   = 16;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

endpackage

// File: rtl/ifetch_unit_fetch_timer.sv
// Clearable saturating up-counter; tc flags TIMEOUT-1 cycles spent waiting on memory.
module fetch_timer
    import ifetch_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int            TW   = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count;

    // Saturates at LAST so a long DROP wait can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + TW'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: requests the word at pc_in from instruction memory and holds it for decode.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int          N         = 32,
    parameter int          TIMEOUT   = TIMEOUT_DEF,
    parameter logic [N-1:0] NOP_INSTR = N'(NOP_INSTR_DEF)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] pc_in,
    input  logic         flush,
    output logic         pc_advance,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] instr_out,
    output logic [N-1:0] instr_pc,
    output logic         instr_valid,
    output logic         instr_err,
    input  logic         instr_ready
);

    fetch_state_e state, state_nxt;

    logic         req_nxt;
    logic [N-1:0] addr_nxt;
    logic [N-1:0] out_nxt;
    logic [N-1:0] ipc_nxt;
    logic         valid_nxt;
    logic         err_nxt;
    logic         tmr_clr;
    logic         tmr_en;
    logic         tmr_tc;

    fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .tc  (tmr_tc)
    );

    always_comb begin
        state_nxt = state;
        req_nxt   = imem_req;
        addr_nxt  = imem_addr;
        out_nxt   = instr_out;
        ipc_nxt   = instr_pc;
        valid_nxt = instr_valid;
        err_nxt   = instr_err;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;

        case (state)
            IDLE: begin
                addr_nxt  = pc_in;
                req_nxt   = 1'b1;
                tmr_clr   = 1'b1;
                state_nxt = REQ;
            end
            REQ: begin
                tmr_en = 1'b1;
                // Ack beats timeout; flush only discards, it never withdraws a live request.
                if (imem_ack || tmr_tc) begin
                    req_nxt = 1'b0;
                    if (flush) begin
                        state_nxt = IDLE;
                    end else begin
                        out_nxt   = imem_ack ? imem_rdata : NOP_INSTR;
                        err_nxt   = ~imem_ack;
                        ipc_nxt   = imem_addr;
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (flush) begin
                    state_nxt = DROP;
                end
            end
            HOLD: begin
                if (flush || instr_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                tmr_en = 1'b1;
                if (imem_ack || tmr_tc) begin
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            instr_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            imem_req    <= req_nxt;
            imem_addr   <= addr_nxt;
            instr_out   <= out_nxt;
            instr_pc    <= ipc_nxt;
            instr_valid <= valid_nxt;
            instr_err   <= err_nxt;
        end
    end

    assign pc_advance = instr_valid & instr_ready & ~flush;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed and randomized bench for ifetch_unit against a transaction-level fetch model.
module tb_ifetch_unit;

    localparam int          N   = 32;
    localparam int          TO  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pc_in;
    logic         flush;
    logic         pc_advance;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack;
    logic [N-1:0] imem_rdata;
    logic [N-1:0] instr_out;
    logic [N-1:0] instr_pc;
    logic         instr_valid;
    logic         instr_err;
    logic         instr_ready;

    int n_cmp = 0;
    int n_err = 0;

    // Random-phase model state: one outstanding request plus the held instruction.
    int          age;
    int          dly;
    int          to_req;
    bit          flushed;
    bit          acked;
    bit          end_exp;
    bit          exp_valid;
    bit          exp_err;
    bit          adv_pending;
    logic [31:0] req_addr;
    logic [31:0] exp_instr;
    logic [31:0] pc_cur;
    logic [31:0] pc_latched;

    always #5 clk = ~clk;

    ifetch_unit #(.N(N), .TIMEOUT(TO), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .flush       (flush),
        .pc_advance  (pc_advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_err   (instr_err),
        .instr_ready (instr_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},   imem_req,    0);
        chk({tag, "_addr"},  imem_addr,   0);
        chk({tag, "_out"},   instr_out,   0);
        chk({tag, "_pc"},    instr_pc,    0);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_err"},   instr_err,   0);
        chk({tag, "_adv"},   pc_advance,  0);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (imem_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, imem_req, 1);
    endtask

    task automatic rand_cycle();
        tick();
        if (to_req > 0) begin
            to_req--;
            chk("rnd_req_idle", imem_req, (to_req == 0));
        end
        if (age > 0) begin
            chk("rnd_req_end", imem_req, !end_exp);
            if (imem_req) begin
                age++;
                chk("rnd_addr_hold", imem_addr, req_addr);
            end else begin
                age = 0;
                if (flushed) begin
                    to_req = 1;
                end else begin
                    exp_valid = 1;
                    exp_err   = !acked;
                    exp_instr = acked ? mem_word(req_addr) : NOP;
                end
            end
        end else if (imem_req) begin
            age      = 1;
            req_addr = pc_latched;
            chk("rnd_addr", imem_addr, req_addr);
            dly      = $urandom_range(20);
            flushed  = 0;
            acked    = 0;
        end
        chk("rnd_valid", instr_valid, exp_valid);
        if (exp_valid) begin
            chk("rnd_out", instr_out, exp_instr);
            chk("rnd_pc",  instr_pc,  req_addr);
            chk("rnd_err", instr_err, exp_err);
            chk("rnd_hold_noreq", imem_req, 0);
        end

        if (adv_pending) pc_cur = pc_cur + 32'd4;
        adv_pending = 0;
        flush = ($urandom_range(99) < 8);
        if (flush) pc_cur = $urandom & 32'hFFFF_FFFC;
        instr_ready = ($urandom_range(99) < 60);
        if (age > 0) begin
            imem_ack   = (age == dly + 1);
            imem_rdata = imem_ack ? mem_word(req_addr) : $urandom;
            acked      = imem_ack;
            if (flush) flushed = 1;
            end_exp    = imem_ack || (age == TO);
        end else begin
            imem_ack   = ($urandom_range(99) < 10);
            imem_rdata = $urandom;
        end
        pc_in      = pc_cur;
        pc_latched = pc_cur;
        #1;
        chk("rnd_adv", pc_advance, exp_valid && instr_ready && !flush);
        if (exp_valid && (instr_ready || flush)) begin
            adv_pending = !flush;
            exp_valid   = 0;
            to_req      = 2;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        rst = 1; flush = 0; imem_ack = 1; imem_rdata = '1; instr_ready = 1; pc_in = 32'h10;
        tick(); tick();
        chk_zero("reset");

        // Basic fetch with one-cycle memory and ready decode.
        rst = 0; imem_ack = 0;
        tick();
        chk("f1_req", imem_req, 1);
        chk("f1_addr", imem_addr, 32'h10);
        chk("f1_valid_early", instr_valid, 0);
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 0;
        chk("f1_valid", instr_valid, 1);
        chk("f1_out", instr_out, 32'hDEAD_BEEF);
        chk("f1_pc", instr_pc, 32'h10);
        chk("f1_err", instr_err, 0);
        chk("f1_req_low", imem_req, 0);
        chk("f1_adv", pc_advance, 1);
        pc_in = 32'h14;
        tick();
        chk("f1_valid_drop", instr_valid, 0);
        chk("f1_adv_once", pc_advance, 0);
        tick();
        chk("f2_req", imem_req, 1);
        chk("f2_addr", imem_addr, 32'h14);

        // Decode stall for five cycles.
        instr_ready = 0; imem_ack = 1; imem_rdata = 32'h1111_2222;
        tick();
        imem_ack = 0;
        repeat (5) begin
            chk("stall_valid", instr_valid, 1);
            chk("stall_out", instr_out, 32'h1111_2222);
            chk("stall_pc", instr_pc, 32'h14);
            chk("stall_adv", pc_advance, 0);
            chk("stall_req", imem_req, 0);
            tick();
        end
        chk("stall_valid_end", instr_valid, 1);
        instr_ready = 1; pc_in = 32'h18;
        #1 chk("stall_adv_release", pc_advance, 1);
        tick();
        chk("stall_valid_drop", instr_valid, 0);
        chk("stall_adv_once", pc_advance, 0);

        // Memory never answers: NOP after exactly TO request cycles.
        wait_req("to_start");
        chk("to_addr", imem_addr, 32'h18);
        cnt = 0;
        while (imem_req === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("to_req_cycles", cnt, TO);
        chk("to_valid", instr_valid, 1);
        chk("to_out", instr_out, NOP);
        chk("to_err", instr_err, 1);
        chk("to_pc", instr_pc, 32'h18);
        chk("to_adv", pc_advance, 1);
        pc_in = 32'h1C;
        tick();

        // Ack lands on the timeout cycle: real data wins.
        wait_req("a16_start");
        chk("a16_addr", imem_addr, 32'h1C);
        repeat (15) tick();
        chk("a16_req_still", imem_req, 1);
        imem_ack = 1; imem_rdata = 32'hCAFE_F00D;
        tick();
        imem_ack = 0;
        chk("a16_valid", instr_valid, 1);
        chk("a16_out", instr_out, 32'hCAFE_F00D);
        chk("a16_err", instr_err, 0);
        chk("a16_pc", instr_pc, 32'h1C);
        pc_in = 32'h20;
        tick();
        wait_req("fl_start");
        chk("fl_addr", imem_addr, 32'h20);

        // Flush mid-request, ack three cycles later.
        flush = 1; pc_in = 32'h100;
        repeat (3) begin
            tick();
            flush = 0;
            chk("drop_req", imem_req, 1);
            chk("drop_valid", instr_valid, 0);
        end
        imem_ack = 1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_ack = 0;
        chk("drop_idle_req", imem_req, 0);
        chk("drop_idle_valid", instr_valid, 0);
        tick();
        chk("drop_refetch", imem_req, 1);
        chk("drop_refetch_addr", imem_addr, 32'h100);

        // Flush coincident with ack.
        flush = 1; imem_ack = 1; imem_rdata = 32'h0BAD_0BAD; pc_in = 32'h200;
        tick();
        flush = 0; imem_ack = 0;
        chk("flack_req", imem_req, 0);
        chk("flack_valid", instr_valid, 0);
        tick();
        chk("flack_refetch", imem_req, 1);
        chk("flack_addr", imem_addr, 32'h200);

        // Flush and ready together in HOLD.
        imem_ack = 1; imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 0;
        chk("flrdy_valid", instr_valid, 1);
        flush = 1; pc_in = 32'h300;
        #1 chk("flrdy_adv", pc_advance, 0);
        tick();
        flush = 0;
        chk("flrdy_drop", instr_valid, 0);
        tick();
        chk("flrdy_refetch", imem_req, 1);
        chk("flrdy_addr", imem_addr, 32'h300);

        // Reset during REQ, then a late ack that must be ignored.
        rst = 1; imem_ack = 1;
        tick();
        chk_zero("rst_req");
        rst = 0;
        tick();
        imem_ack = 0;
        chk("late_ack_valid", instr_valid, 0);
        chk("late_ack_req", imem_req, 1);
        chk("late_ack_addr", imem_addr, 32'h300);

        // Reset during HOLD.
        instr_ready = 0; imem_ack = 1; imem_rdata = 32'h55AA_55AA;
        tick();
        imem_ack = 0;
        chk("rsthold_valid", instr_valid, 1);
        rst = 1;
        tick();
        chk_zero("rst_hold");
        rst = 0;

        age = 0; to_req = 1; exp_valid = 0; adv_pending = 0; end_exp = 0;
        flushed = 0; acked = 0;
        pc_cur = pc_in; pc_latched = pc_in;
        repeat (3000) rand_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
